// File: rtl/alu_mul_sequencer_if.sv
// Multiply request/response bundle between the CPU control unit and alu_mul_sequencer.
// The master (CPU side) issues start with operands; the slave returns busy/done/product.
interface alu_mul_sequencer_if;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (output start, mcand, mplier, input busy, done, product);
    modport slave  (input start, mcand, mplier, output busy, done, product);
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned 8x8 shift-and-add multiplier that borrows the MiniRISC ALU (ADD + ROR-through-carry).
// Macro MUL_FLAG_RESTORE_EN: save the ALU flags at start and write them back before done.
//
// state   | meaning
// IDLE    | ALU passes CPU controls through, waits for start
// ADD     | hi += (lo[0] ? mc : 0), carry lands in ALU C
// RORH    | rotate {C,hi} right through carry
// RORL    | rotate {C,lo} right through carry, count iteration
// RESTORE | write saved flags back (MUL_FLAG_RESTORE_EN only)
// FIN     | done pulse, product = {hi,lo}
module alu_mul_sequencer #(
    parameter bit EARLY_DONE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    alu_mul_sequencer_if.slave  mul,
    input  logic [1:0]          cpu_op_type,
    input  logic [1:0]          cpu_arith_sel,
    input  logic [1:0]          cpu_logic_sel,
    input  logic [3:0]          cpu_shift_sel,
    input  logic [7:0]          cpu_operand1,
    input  logic [7:0]          cpu_operand2,
    input  logic [3:0]          cpu_flag_din,
    input  logic                cpu_flag_wr,
    output logic [1:0]          alu_op_type,
    output logic [1:0]          alu_arith_sel,
    output logic [1:0]          alu_logic_sel,
    output logic [3:0]          alu_shift_sel,
    output logic [7:0]          alu_operand1,
    output logic [7:0]          alu_operand2,
    output logic [3:0]          alu_flag_din,
    output logic                alu_flag_wr,
    input  logic [7:0]          alu_result,
    input  logic                alu_flag_z,
    input  logic                alu_flag_c,
    input  logic                alu_flag_n,
    input  logic                alu_flag_v
);
    localparam logic [1:0] ALU_ARITH = 2'b00;
    localparam logic [1:0] ALU_SHIFT = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADD     = 3'd1;
    localparam logic [2:0] S_RORH    = 3'd2;
    localparam logic [2:0] S_RORL    = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd5;
`ifdef MUL_FLAG_RESTORE_EN
    localparam logic [2:0] S_RESTORE = 3'd4;
    localparam logic [1:0] ALU_MOVE  = 2'b11;
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
`endif

    logic [2:0]  state_q, state_d;
    logic [7:0]  mc_q, mc_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic        seq_own;
`ifdef MUL_FLAG_RESTORE_EN
    logic [3:0]  flags_q, flags_d;
`else
    logic        unused_flags;
    assign unused_flags = ^{alu_flag_z, alu_flag_c, alu_flag_n, alu_flag_v};
`endif

`ifdef MUL_FLAG_RESTORE_EN
    assign seq_own = (state_q == S_ADD) || (state_q == S_RORH) ||
                     (state_q == S_RORL) || (state_q == S_RESTORE);
`else
    assign seq_own = (state_q == S_ADD) || (state_q == S_RORH) || (state_q == S_RORL);
`endif

    assign mul.busy    = seq_own;
    assign mul.done    = (state_q == S_FIN);
    assign mul.product = (state_q == S_FIN) ? {hi_q, lo_q} : product_q;

    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef MUL_FLAG_RESTORE_EN
        flags_d   = flags_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mul.start) begin
                    mc_d    = mul.mcand;
                    hi_d    = 8'h00;
                    lo_d    = mul.mplier;
                    cnt_d   = 3'd0;
                    state_d = S_ADD;
`ifdef MUL_FLAG_RESTORE_EN
                    flags_d[FLAG_Z] = alu_flag_z;
                    flags_d[FLAG_C] = alu_flag_c;
                    flags_d[FLAG_N] = alu_flag_n;
                    flags_d[FLAG_V] = alu_flag_v;
`endif
                    if (EARLY_DONE && ((mul.mcand == 8'h00) || (mul.mplier == 8'h00))) begin
                        lo_d    = 8'h00;
                        state_d = S_FIN;
                    end
                end
            end
            S_ADD: begin
                hi_d    = alu_result;
                state_d = S_RORH;
            end
            S_RORH: begin
                hi_d    = alu_result;
                state_d = S_RORL;
            end
            S_RORL: begin
                lo_d = alu_result;
                if (cnt_q == 3'd7) begin
`ifdef MUL_FLAG_RESTORE_EN
                    state_d = S_RESTORE;
`else
                    state_d = S_FIN;
`endif
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = S_ADD;
                end
            end
`ifdef MUL_FLAG_RESTORE_EN
            S_RESTORE: state_d = S_FIN;
`endif
            S_FIN: begin
                product_d = {hi_q, lo_q};
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outside the sequencing states the CPU owns the ALU unchanged.
    always_comb begin
        alu_op_type   = cpu_op_type;
        alu_arith_sel = cpu_arith_sel;
        alu_logic_sel = cpu_logic_sel;
        alu_shift_sel = cpu_shift_sel;
        alu_operand1  = cpu_operand1;
        alu_operand2  = cpu_operand2;
        alu_flag_din  = cpu_flag_din;
        alu_flag_wr   = cpu_flag_wr;
        if (seq_own) begin
            alu_op_type   = ALU_ARITH;
            alu_arith_sel = 2'b00;
            alu_logic_sel = 2'b00;
            alu_shift_sel = 4'b0000;
            alu_operand1  = 8'h00;
            alu_operand2  = 8'h00;
            alu_flag_din  = 4'b0000;
            alu_flag_wr   = 1'b0;
            case (state_q)
                S_ADD: begin
                    alu_operand1 = hi_q;
                    alu_operand2 = lo_q[0] ? mc_q : 8'h00;
                end
                S_RORH: begin
                    alu_op_type   = ALU_SHIFT;
                    alu_shift_sel = {1'b0, 1'b1, SHIFT_ROR};
                    alu_operand1  = hi_q;
                end
                S_RORL: begin
                    alu_op_type   = ALU_SHIFT;
                    alu_shift_sel = {1'b0, 1'b1, SHIFT_ROR};
                    alu_operand1  = lo_q;
                end
`ifdef MUL_FLAG_RESTORE_EN
                S_RESTORE: begin
                    alu_op_type  = ALU_MOVE;
                    alu_flag_din = flags_q;
                    alu_flag_wr  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mc_q      <= 8'h00;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            cnt_q     <= 3'd0;
            product_q <= 16'h0000;
`ifdef MUL_FLAG_RESTORE_EN
            flags_q   <= 4'b0000;
`endif
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef MUL_FLAG_RESTORE_EN
            flags_q   <= flags_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: two instances (EARLY_DONE 0 and 1), each driving a small ALU model,
// checked every cycle against a timing/arithmetic reference model plus literal pins.
`timescale 1ns/1ps
module tb_alu_mul_sequencer;
    localparam logic [1:0] OP_ARITH = 2'b00;
    localparam logic [1:0] OP_LOGIC = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_MOVE  = 2'b11;
`ifdef MUL_FLAG_RESTORE_EN
    localparam int RESTORE = 1;
`else
    localparam int RESTORE = 0;
`endif
    localparam int DONE_PH = 25 + RESTORE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] mcand, mplier;
    logic [1:0] cpu_op_type, cpu_arith_sel, cpu_logic_sel;
    logic [3:0] cpu_shift_sel, cpu_flag_din;
    logic [7:0] cpu_operand1, cpu_operand2;
    logic       cpu_flag_wr;
    logic       rnd_cpu = 1'b1;
    logic       chk_en = 1'b0;
    int         total = 0, passed = 0, fails = 0;
    int         ncyc = 0;

    always @(posedge clk) ncyc = ncyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            passed = passed + 1;
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam bit ED = (g == 1);
        alu_mul_sequencer_if mif ();
        logic [1:0] a_op, a_ar, a_lg;
        logic [3:0] a_sh, a_fd;
        logic [7:0] a_o1, a_o2, a_res;
        logic       a_fw;
        logic       fz = 1'b0, fc = 1'b0, fn = 1'b0, fv = 1'b0;
        logic [8:0] sum;

        assign mif.start  = start;
        assign mif.mcand  = mcand;
        assign mif.mplier = mplier;

        alu_mul_sequencer #(.EARLY_DONE(ED)) dut (
            .clk(clk), .rst(rst), .mul(mif),
            .cpu_op_type(cpu_op_type), .cpu_arith_sel(cpu_arith_sel),
            .cpu_logic_sel(cpu_logic_sel), .cpu_shift_sel(cpu_shift_sel),
            .cpu_operand1(cpu_operand1), .cpu_operand2(cpu_operand2),
            .cpu_flag_din(cpu_flag_din), .cpu_flag_wr(cpu_flag_wr),
            .alu_op_type(a_op), .alu_arith_sel(a_ar), .alu_logic_sel(a_lg),
            .alu_shift_sel(a_sh), .alu_operand1(a_o1), .alu_operand2(a_o2),
            .alu_flag_din(a_fd), .alu_flag_wr(a_fw), .alu_result(a_res),
            .alu_flag_z(fz), .alu_flag_c(fc), .alu_flag_n(fn), .alu_flag_v(fv)
        );

        // ALU stand-in: combinational result, registered flags.
        always_comb begin
            sum = {1'b0, a_o1} + {1'b0, a_o2} + ((a_ar == 2'b01) ? {8'h00, fc} : 9'd0);
            case (a_op)
                OP_ARITH: a_res = sum[7:0];
                OP_LOGIC: case (a_lg)
                    2'b00:   a_res = a_o1 & a_o2;
                    2'b01:   a_res = a_o1 | a_o2;
                    2'b10:   a_res = a_o1 ^ a_o2;
                    default: a_res = ~a_o1;
                endcase
                OP_SHIFT: a_res = (a_sh[1:0] == 2'b11) ? {(a_sh[2] ? fc : a_o1[0]), a_o1[7:1]} : a_o1;
                default:  a_res = a_o2;
            endcase
        end

        always @(posedge clk) begin
            if (a_fw) begin
                {fv, fn, fc, fz} <= a_fd;
            end else begin
                case (a_op)
                    OP_ARITH: begin
                        fz <= (sum[7:0] == 8'h00); fn <= sum[7]; fc <= sum[8];
                        fv <= (a_o1[7] == a_o2[7]) && (sum[7] != a_o1[7]);
                    end
                    OP_LOGIC: begin fz <= (a_res == 8'h00); fn <= a_res[7]; end
                    OP_SHIFT: begin
                        fz <= (a_res == 8'h00); fn <= a_res[7];
                        if (a_sh[1:0] == 2'b11) fc <= a_o1[0];
                    end
                    default: ;
                endcase
            end
        end

        // Reference model: phase since the accepted start, operands, held product.
        int          ph = 0, len = DONE_PH;
        logic [7:0]  m_mc = 8'h00, m_mp = 8'h00;
        logic [15:0] m_prod = 16'h0000;
        logic [3:0]  m_saved = 4'h0;

        always @(posedge clk) begin
            if (rst) begin
                ph = 0; m_prod = 16'h0000;
            end else if (ph == 0) begin
                if (start) begin
                    m_mc = mcand; m_mp = mplier; m_saved = {fv, fn, fc, fz};
                    len = (ED && (mcand == 8'h00 || mplier == 8'h00)) ? 1 : DONE_PH;
                    ph = 1;
                end
            end else if (ph == len) begin
                ph = 0; m_prod = {8'h00, m_mc} * {8'h00, m_mp};
            end else begin
                ph = ph + 1;
            end
        end

        int          bcount = 0, dcount = 0, done_at = 0;
        logic [15:0] last_prod = 16'h0000;
        logic [3:0]  done_flags = 4'h0;

        always @(negedge clk) begin
            if (mif.busy) bcount = bcount + 1;
            if (mif.done) begin
                dcount = dcount + 1; last_prod = mif.product;
                done_flags = {fv, fn, fc, fz}; done_at = ncyc;
            end
        end

        always @(negedge clk) begin : compare
            logic [30:0] cpu_v, alu_v, ev;
            logic [15:0] full;
            logic [7:0]  eh, el, addend, h2;
            int          k, i, acc;
            logic        eb, edn;
            if (chk_en) begin
                cpu_v = {cpu_op_type, cpu_arith_sel, cpu_logic_sel, cpu_shift_sel,
                         cpu_operand1, cpu_operand2, cpu_flag_din, cpu_flag_wr};
                alu_v = {a_op, a_ar, a_lg, a_sh, a_o1, a_o2, a_fd, a_fw};
                full  = {8'h00, m_mc} * {8'h00, m_mp};
                eb    = (ph != 0) && (ph < len);
                edn   = (ph != 0) && (ph == len);
                chk($sformatf("i%0d_busy", g), mif.busy, eb);
                chk($sformatf("i%0d_done", g), mif.done, edn);
                if (!eb) begin
                    chk($sformatf("i%0d_passthru", g), alu_v, cpu_v);
                    chk($sformatf("i%0d_product", g), mif.product, edn ? full : m_prod);
                    if (edn && len != 1) begin
                        if (RESTORE == 1)
                            chk($sformatf("i%0d_flags_restored", g), {fv, fn, fc, fz}, m_saved);
                        else
                            chk($sformatf("i%0d_flags_last_ror", g), {fn, fc, fz},
                                {full[7], m_mp[7], full[7:0] == 8'h00});
                    end
                end else begin
                    k = ph - 1;
                    if (k < 24) begin
                        i  = k / 3;
                        // {hi,lo} after i iterations: partial product on top, unused multiplier bits below
                        acc = ((int'(m_mc) * (int'(m_mp) & ((1 << i) - 1))) << (8 - i)) | (int'(m_mp) >> i);
                        eh = acc[15:8]; el = acc[7:0];
                        addend = m_mp[i] ? m_mc : 8'h00;
                        h2 = eh + addend;
                        case (k % 3)
                            0:       ev = {OP_ARITH, 2'b00, 2'b00, 4'b0000, eh, addend, 4'b0000, 1'b0};
                            1:       ev = {OP_SHIFT, 2'b00, 2'b00, 4'b0111, h2, 8'h00, 4'b0000, 1'b0};
                            default: ev = {OP_SHIFT, 2'b00, 2'b00, 4'b0111, el, 8'h00, 4'b0000, 1'b0};
                        endcase
                    end else begin
                        ev = {OP_MOVE, 2'b00, 2'b00, 4'b0000, 8'h00, 8'h00, m_saved, 1'b1};
                    end
                    chk($sformatf("i%0d_alu_drive_ph%0d", g, ph), alu_v, ev);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rnd_cpu) begin
                cpu_op_type   = 2'($urandom); cpu_arith_sel = 2'($urandom);
                cpu_logic_sel = 2'($urandom); cpu_shift_sel = 4'($urandom);
                cpu_operand1  = 8'($urandom); cpu_operand2  = 8'($urandom);
                cpu_flag_din  = 4'($urandom); cpu_flag_wr   = 1'($urandom);
            end
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1; mcand = a; mplier = b;
        cyc(1);
        start = 1'b0; mcand = 8'($urandom); mplier = 8'($urandom);
    endtask

    int b0, b1, d0, d1, t0;

    task automatic snap();
        b0 = gi[0].bcount; b1 = gi[1].bcount; d0 = gi[0].dcount; d1 = gi[1].dcount; t0 = ncyc;
    endtask

    task automatic pins(input string nm, input logic [15:0] prod);
        chk({nm, "_prod0"}, gi[0].last_prod, prod);
        chk({nm, "_prod1"}, gi[1].last_prod, prod);
        chk({nm, "_busy0"}, gi[0].bcount - b0, 24 + RESTORE);
        chk({nm, "_dcnt0"}, gi[0].dcount - d0, 1);
        chk({nm, "_done_cycle0"}, gi[0].done_at - t0, DONE_PH);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mcand = 8'h00; mplier = 8'h00;
        cpu_op_type = 2'b00; cpu_arith_sel = 2'b00; cpu_logic_sel = 2'b00; cpu_shift_sel = 4'h0;
        cpu_operand1 = 8'h00; cpu_operand2 = 8'h00; cpu_flag_din = 4'h0; cpu_flag_wr = 1'b0;
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        rst = 1'b0;

        rnd_cpu = 1'b0;
        cpu_op_type = OP_LOGIC; cpu_operand1 = 8'h3C; cpu_flag_wr = 1'b1; cpu_flag_din = 4'hA;
        cyc(3);
        rnd_cpu = 1'b1;

        // 13*11 with ignored start pulses in cycles 5 and 25
        snap();
        launch(8'd13, 8'd11);
        cyc(4);
        start = 1'b1; mcand = 8'd99; mplier = 8'd77;
        cyc(1);
        start = 1'b0;
        cyc(19);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        pins("m13x11", 16'h008F);
        chk("m13x11_dcnt1", gi[1].dcount - d1, 1);

        snap(); launch(8'hFF, 8'hFF); cyc(DONE_PH + 2); pins("mFFxFF", 16'hFE01);
        snap(); launch(8'h80, 8'h02); cyc(DONE_PH + 2); pins("m80x02", 16'h0100);

        snap(); launch(8'h00, 8'h5A); cyc(DONE_PH + 2);
        chk("m0x5A_prod0", gi[0].last_prod, 16'h0000);
        chk("m0x5A_busy0", gi[0].bcount - b0, 24 + RESTORE);
        chk("m0x5A_busy1_early", gi[1].bcount - b1, 0);
        chk("m0x5A_done_cycle1_early", gi[1].done_at - t0, 1);
        chk("m0x5A_dcnt1", gi[1].dcount - d1, 1);

        // preset flags Z=1 C=0 N=1 V=1, then 3*5 with the CPU issuing flag-neutral moves
        rnd_cpu = 1'b0;
        cpu_op_type = OP_MOVE; cpu_flag_wr = 1'b1; cpu_flag_din = 4'b1101;
        cyc(1);
        cpu_flag_wr = 1'b0;
        snap(); launch(8'd3, 8'd5); cyc(DONE_PH + 2);
        pins("m3x5", 16'h000F);
        if (RESTORE == 1) chk("m3x5_flags", gi[0].done_flags, 4'b1101);
        else              chk("m3x5_flags_nzc", gi[0].done_flags[2:0], 3'b000);
        rnd_cpu = 1'b1;

        // reset in cycle 10 of a multiply, then rerun
        launch(8'hB7, 8'h6D);
        cyc(9);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        snap(); launch(8'hB7, 8'h6D); cyc(DONE_PH + 2); pins("mB7x6D", 16'h4DEB);

        // random operands, random start pulses while busy, rare resets
        for (int n = 0; n < 30; n++) begin
            launch(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                   ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
            for (int c = 0; c < DONE_PH; c++) begin
                start = ($urandom_range(0, 7) == 0);
                rst   = ($urandom_range(0, 99) == 0);
                mcand = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                mplier = 8'($urandom);
                cyc(1);
            end
            start = 1'b0; rst = 1'b0;
            cyc($urandom_range(1, 3));
        end
        cyc(DONE_PH + 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
